barrier_tracker: RTL and testbench
==================================

BARRIER_TRACKER -- requirements
Module: barrier_tracker

Interface
REQ-001 Parameter PARTICIPANTS, default 4, number of participant arrive lines (>=1).
REQ-002 Parameter BARRIERS, default 2, number of independent barriers (>=1); BID_W = max(1, $clog2(BARRIERS)).
REQ-003 Parameter GEN_W, default 2, generation counter width per barrier.
REQ-004 Parameter TIMEOUT, default 0, timeout in cycles from the first arrival of a generation; 0 disables timeout.
REQ-005 Parameter COMB, default 0; 1 = release in the completion cycle, 0 = release one cycle later (registered).
REQ-006 clk_i  input  1  single clock, all state on rising edge.
REQ-007 rst_i  input  1  reset, asynchronous and active-high.
REQ-008 cfg_valid_i  input  1  mask-write request.
REQ-009 cfg_bar_i  input  BID_W  target barrier of the mask write.
REQ-010 cfg_mask_i  input  PARTICIPANTS  new participant mask.
REQ-011 cfg_ready_o  output  1  mask write is accepted this cycle.
REQ-012 arrive_i  input  PARTICIPANTS  one-cycle arrival pulse per participant.
REQ-013 arrive_bar_i  input  PARTICIPANTS*BID_W  barrier id of each participant's arrival, slice p at [p*BID_W +: BID_W].
REQ-014 abort_i  input  BARRIERS  per-barrier abort of the current generation.
REQ-015 release_o  output  BARRIERS  one-cycle pulse per barrier on completion.
REQ-016 gen_o  output  BARRIERS*GEN_W  completed-generation count per barrier.
REQ-017 timeout_o  output  BARRIERS  one-cycle pulse when a generation times out.
REQ-018 error_o  output  BARRIERS  one-cycle pulse on an illegal arrival to that barrier.
REQ-019 bad_id_o  output  1  one-cycle pulse when any arrival carries an id >= BARRIERS.
REQ-020 armed_o  output  BARRIERS  barrier holds a nonzero mask.

Function
REQ-021 Per barrier b, the block shall hold mask_q[b], arrived_q[b] (PARTICIPANTS bits), gen_q[b] (GEN_W bits), and timer_q[b].
REQ-022 Barrier states: IDLE (mask_q==0), WAIT (mask_q!=0); armed_o[b] shall be 1 exactly in WAIT.
REQ-023 cfg_ready_o shall be 1 iff cfg_bar_i < BARRIERS and arrived_q[cfg_bar_i]==0; on valid&ready, mask_q is loaded at the next edge, and gen_q and timer_q are cleared.
REQ-024 Arrivals in the same cycle as an accepted mask write shall be evaluated against the old mask.
REQ-025 A legal arrival shall be arrive_i[p]=1 with id b<BARRIERS, mask_q[b][p]=1, and arrived_q[b][p]=0; it shall set arrived_q[b][p].
REQ-026 An arrival to an unmasked participant or a duplicate within a generation shall pulse error_o[b] in the next cycle and shall leave state unchanged.
REQ-027 An out-of-range id shall pulse bad_id_o in the next cycle and shall be otherwise ignored.
REQ-028 Completion of barrier b shall be ((arrived_q[b] | legal_new[b]) & mask_q[b]) == mask_q[b] with mask_q[b] != 0.
REQ-029 On completion, arrived_q[b] and timer_q[b] shall clear at the next edge, and gen_q[b] shall increment modulo 2^GEN_W.
REQ-030 COMB=1: release_o[b] shall be high combinationally in the completion cycle; COMB=0: release_o[b] shall be high in the following cycle only.
REQ-031 Arrivals in the cycle after completion shall count toward the next generation; the mask is retained, so the barrier auto-rearms.
REQ-032 TIMEOUT>0: timer_q[b] shall start at the first legal arrival of a generation and increment each cycle while incomplete.
REQ-033 On timeout (timer_q[b] reaching TIMEOUT-1 without completion), timeout_o[b] shall pulse next cycle, arrived_q[b] and timer_q[b] shall clear, and gen_q[b] shall be unchanged.
REQ-034 If completion and timeout occur in the same cycle, completion shall win.
REQ-035 abort_i[b] shall clear arrived_q[b] and timer_q[b] at the next edge, shall take priority over same-cycle arrivals, completion and timeout, and the dropped arrivals shall not raise error_o.
REQ-036 Barriers shall be fully independent; one participant may arrive at one barrier per cycle only.
REQ-037 All error, timeout, bad_id and (COMB=0) release pulses shall be registered.

Reset
REQ-038 rst_i high shall immediately clear all state; all outputs shall be 0 during and after reset, except cfg_ready_o, which follows REQ-023 (1 for a valid id).
REQ-039 Assertion of rst_i mid-generation shall discard arrivals without a release pulse; the barrier is IDLE after deassertion.

Verification (P=4, B=2, GEN_W=2, TIMEOUT=16 unless noted)
REQ-040 Write mask 4'b1011 to barrier 0; arrivals p0, p1, then p3 on separate cycles -> release_o[0] one cycle after the p3 cycle (COMB=0), gen_o[0]=1; with COMB=1, release in the p3 cycle.
REQ-041 Complete barrier 0 four times -> gen_o[0] wraps 3->0; p0 arriving in the cycle after completion counts toward the next generation.
REQ-042 Arrive p2 (unmasked) and then p0 twice -> error_o[0] pulses twice, and arrived_q[0] = 4'b0001 only.
REQ-043 Arrive p0 only, then wait -> timeout_o[0] pulses 16 cycles later, gen_o[0] unchanged, and the next full set releases normally.
REQ-044 Arrive p0 at barrier 0 and p1 at barrier 1 in the same cycle, with id 3 on p2 and abort_i[1] in the same cycle -> bad_id_o pulses, barrier 1 stays empty with no error, and barrier 0 holds p0.
REQ-045 Attempt a cfg write to barrier 0 while arrived_q[0]!=0 -> cfg_ready_o=0; assert rst_i mid-generation -> all outputs 0 and armed_o=0.

Source files
------------

// File: rtl/barrier_tracker.sv
// rtl/barrier_tracker.sv - multi-barrier arrival tracker with generations, timeout and abort
module barrier_tracker #(
    parameter int PARTICIPANTS = 4,
    parameter int BARRIERS     = 2,
    parameter int GEN_W        = 2,
    parameter int TIMEOUT      = 0,
    parameter bit COMB         = 1'b0,
    localparam int BID_W       = (BARRIERS > 1) ? $clog2(BARRIERS) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cfg_valid_i,
    input  logic [BID_W-1:0]              cfg_bar_i,
    input  logic [PARTICIPANTS-1:0]       cfg_mask_i,
    output logic                          cfg_ready_o,
    input  logic [PARTICIPANTS-1:0]       arrive_i,
    input  logic [PARTICIPANTS*BID_W-1:0] arrive_bar_i,
    input  logic [BARRIERS-1:0]           abort_i,
    output logic [BARRIERS-1:0]           release_o,
    output logic [BARRIERS*GEN_W-1:0]     gen_o,
    output logic [BARRIERS-1:0]           timeout_o,
    output logic [BARRIERS-1:0]           error_o,
    output logic                          bad_id_o,
    output logic [BARRIERS-1:0]           armed_o
);

    // Timer counts cycles since the first arrival; the arrival cycle itself is cycle 0.
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

    logic [BARRIERS-1:0][PARTICIPANTS-1:0] r_mask;
    logic [BARRIERS-1:0][PARTICIPANTS-1:0] r_arrived;
    logic [BARRIERS-1:0][GEN_W-1:0]        r_gen;
    logic [BARRIERS-1:0][TMR_W-1:0]        r_timer;
    logic [BARRIERS-1:0]                   r_timeout;
    logic [BARRIERS-1:0]                   r_error;
    logic                                  r_bad_id;

    logic [BARRIERS-1:0][PARTICIPANTS-1:0] w_hit;
    logic [BARRIERS-1:0][PARTICIPANTS-1:0] w_legal;
    logic [BARRIERS-1:0]                   w_illegal;
    logic [BARRIERS-1:0]                   w_complete;
    logic [BARRIERS-1:0]                   w_timeout;
    logic [BARRIERS-1:0]                   w_cfg_sel;
    logic [BARRIERS-1:0]                   w_busy;
    logic                                  w_bad_id;
    logic                                  w_cfg_take;

    // Route each participant's arrival to its target barrier, flag out-of-range ids.
    always_comb begin
        w_hit    = '0;
        w_bad_id = 1'b0;
        for (int p = 0; p < PARTICIPANTS; p++) begin
            if (arrive_i[p]) begin
                if (int'(arrive_bar_i[p*BID_W +: BID_W]) >= BARRIERS) begin
                    w_bad_id = 1'b1;
                end
                for (int b = 0; b < BARRIERS; b++) begin
                    if (arrive_bar_i[p*BID_W +: BID_W] == BID_W'(b)) begin
                        w_hit[b][p] = 1'b1;
                    end
                end
            end
        end
    end

    // Per-barrier classification of arrivals and completion / timeout detection.
    always_comb begin
        w_legal    = '0;
        w_illegal  = '0;
        w_complete = '0;
        w_timeout  = '0;
        w_cfg_sel  = '0;
        w_busy     = '0;
        for (int b = 0; b < BARRIERS; b++) begin
            w_legal[b]    = w_hit[b] & r_mask[b] & ~r_arrived[b];
            w_illegal[b]  = |(w_hit[b] & ~(r_mask[b] & ~r_arrived[b]));
            w_busy[b]     = |r_arrived[b];
            // Abort dominates everything, so it also suppresses completion here.
            w_complete[b] = (|r_mask[b])
                          && (((r_arrived[b] | w_legal[b]) & r_mask[b]) == r_mask[b])
                          && !abort_i[b];
            // Completion wins over a timeout landing in the same cycle.
            w_timeout[b]  = (TIMEOUT > 0) && w_busy[b] && (r_timer[b] >= TMR_LAST)
                          && !w_complete[b] && !abort_i[b];
            w_cfg_sel[b]  = (cfg_bar_i == BID_W'(b));
        end
    end

    // A mask may only change between generations of an in-range barrier.
    assign cfg_ready_o = |(w_cfg_sel & ~w_busy);
    assign w_cfg_take  = cfg_valid_i & cfg_ready_o;

    // Barrier state update and registered event pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mask    <= '0;
            r_arrived <= '0;
            r_gen     <= '0;
            r_timer   <= '0;
            r_timeout <= '0;
            r_error   <= '0;
            r_bad_id  <= 1'b0;
        end else begin
            for (int b = 0; b < BARRIERS; b++) begin
                if (abort_i[b] || w_complete[b] || w_timeout[b]) begin
                    r_arrived[b] <= '0;
                    r_timer[b]   <= '0;
                end else begin
                    r_arrived[b] <= r_arrived[b] | w_legal[b];
                    if ((TIMEOUT > 0) && (|(r_arrived[b] | w_legal[b]))) begin
                        r_timer[b] <= r_timer[b] + TMR_W'(1);
                    end
                end
                if (w_cfg_take && w_cfg_sel[b]) begin
                    r_mask[b]  <= cfg_mask_i;
                    r_gen[b]   <= '0;
                    r_timer[b] <= '0;
                end else if (w_complete[b]) begin
                    r_gen[b] <= r_gen[b] + GEN_W'(1);
                end
            end
            r_timeout <= w_timeout;
            r_error   <= w_illegal & ~abort_i;
            r_bad_id  <= w_bad_id;
        end
    end

    generate
        if (COMB) begin : g_rel_comb
            assign release_o = w_complete;
        end else begin : g_rel_reg
            logic [BARRIERS-1:0] r_release;
            // Release one cycle after the completing arrivals.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_release <= '0;
                end else begin
                    r_release <= w_complete;
                end
            end
            assign release_o = r_release;
        end
    endgenerate

    assign gen_o     = r_gen;
    assign timeout_o = r_timeout;
    assign error_o   = r_error;
    assign bad_id_o  = r_bad_id;

    // A barrier is armed whenever it holds a nonzero participant mask.
    always_comb begin
        armed_o = '0;
        for (int b = 0; b < BARRIERS; b++) begin
            armed_o[b] = |r_mask[b];
        end
    end

endmodule

// File: tb/tb_barrier_tracker.sv
// tb/tb_barrier_tracker.sv - scoreboard bench for barrier_tracker (registered and combinational release)
module tb_barrier_tracker;

    localparam int P  = 4;
    localparam int B  = 3;
    localparam int GW = 2;
    localparam int TO = 16;
    localparam int BW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cfg_valid;
    logic [BW-1:0] cfg_bar;
    logic [P-1:0] cfg_mask;
    logic [P-1:0] arrive;
    logic [P*BW-1:0] arrive_bar;
    logic [B-1:0] abort;

    logic cfg_ready, cfg_ready_c;
    logic [B-1:0] rel, rel_c, tmo, tmo_c, err, err_c, armed, armed_c;
    logic [B*GW-1:0] gen, gen_c;
    logic bad, bad_c;

    barrier_tracker #(.PARTICIPANTS(P), .BARRIERS(B), .GEN_W(GW), .TIMEOUT(TO), .COMB(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_bar_i(cfg_bar), .cfg_mask_i(cfg_mask),
        .cfg_ready_o(cfg_ready), .arrive_i(arrive), .arrive_bar_i(arrive_bar), .abort_i(abort),
        .release_o(rel), .gen_o(gen), .timeout_o(tmo), .error_o(err), .bad_id_o(bad), .armed_o(armed)
    );

    barrier_tracker #(.PARTICIPANTS(P), .BARRIERS(B), .GEN_W(GW), .TIMEOUT(TO), .COMB(1'b1)) dut_c (
        .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_bar_i(cfg_bar), .cfg_mask_i(cfg_mask),
        .cfg_ready_o(cfg_ready_c), .arrive_i(arrive), .arrive_bar_i(arrive_bar), .abort_i(abort),
        .release_o(rel_c), .gen_o(gen_c), .timeout_o(tmo_c), .error_o(err_c), .bad_id_o(bad_c), .armed_o(armed_c)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;
    logic mon_en = 1'b0;

    typedef struct {
        int cyc;
        logic [B-1:0] rel;
        logic [B-1:0] err;
        logic [B-1:0] tmo;
        logic bad;
    } rec_t;

    rec_t q_reg[$];
    rec_t q_comb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_cnt);
        end
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Every cycle: pop the expected pulses for this cycle (or all-zero if none queued) and compare.
    always @(negedge clk) begin
        if (mon_en) begin
            rec_t r;
            rec_t c;
            r = '{cyc: cyc_cnt, rel: '0, err: '0, tmo: '0, bad: 1'b0};
            c = r;
            while (q_reg.size() > 0 && q_reg[0].cyc < cyc_cnt) void'(q_reg.pop_front());
            while (q_comb.size() > 0 && q_comb[0].cyc < cyc_cnt) void'(q_comb.pop_front());
            if (q_reg.size() > 0 && q_reg[0].cyc == cyc_cnt) r = q_reg.pop_front();
            if (q_comb.size() > 0 && q_comb[0].cyc == cyc_cnt) c = q_comb.pop_front();
            check_eq("release", 32'(rel), 32'(r.rel));
            check_eq("error", 32'(err), 32'(r.err));
            check_eq("timeout", 32'(tmo), 32'(r.tmo));
            check_eq("bad_id", 32'(bad), 32'(r.bad));
            check_eq("release_comb", 32'(rel_c), 32'(c.rel));
        end
    end

    function automatic logic [P*BW-1:0] ids(input int i0, input int i1, input int i2, input int i3);
        return {2'(i3), 2'(i2), 2'(i1), 2'(i0)};
    endfunction

    // Drive one cycle of arrivals/aborts; expected pulses are those of the following cycle
    // (registered DUT) and of this same cycle for the combinational-release DUT.
    task automatic cyc(input logic [P-1:0] a, input logic [P*BW-1:0] ab, input logic [B-1:0] abt,
                       input logic [B-1:0] e_rel, input logic [B-1:0] e_err,
                       input logic [B-1:0] e_tmo, input logic e_bad);
        rec_t r;
        arrive     = a;
        arrive_bar = ab;
        abort      = abt;
        r.cyc = cyc_cnt + 1; r.rel = e_rel; r.err = e_err; r.tmo = e_tmo; r.bad = e_bad;
        q_reg.push_back(r);
        r.cyc = cyc_cnt; r.err = '0; r.tmo = '0; r.bad = 1'b0;
        q_comb.push_back(r);
        @(posedge clk); #1;
        arrive     = '0;
        arrive_bar = '0;
        abort      = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, '0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic cfg_write(input logic [BW-1:0] b, input logic [P-1:0] m);
        cfg_valid = 1'b1;
        cfg_bar   = b;
        cfg_mask  = m;
        #1;
        check_eq("cfg_ready_write", 32'(cfg_ready), 32'd1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        cfg_bar   = '0;
        cfg_mask  = '0;
    endtask

    initial begin
        cfg_valid = 1'b0; cfg_bar = '0; cfg_mask = '0;
        arrive = '0; arrive_bar = '0; abort = '0;
        #1 rst = 1'b1;
        mon_en = 1'b1;
        #1;
        check_eq("rst_armed", 32'(armed), 32'd0);
        check_eq("rst_gen", 32'(gen), 32'd0);
        check_eq("rst_release", 32'(rel), 32'd0);
        check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        cfg_bar = 2'd3;
        #1;
        check_eq("cfg_ready_bad_bar", 32'(cfg_ready), 32'd0);
        cfg_bar = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        // Basic generation on barrier 0 with mask 1011.
        cfg_write(2'd0, 4'b1011);
        check_eq("armed_b0", 32'(armed), 32'b001);
        check_eq("gen0_init", 32'(gen[1:0]), 32'd0);
        cyc(4'b0001, ids(0,0,0,0), '0, '0, '0, '0, 1'b0);
        check_eq("cfg_ready_busy", 32'(cfg_ready), 32'd0);
        cyc(4'b0010, ids(0,0,0,0), '0, '0, '0, '0, 1'b0);
        cyc(4'b1000, ids(0,0,0,0), '0, 3'b001, '0, '0, 1'b0);
        check_eq("gen0_1", 32'(gen[1:0]), 32'd1);

        // Back-to-back generations, wrap of the generation counter.
        cyc(4'b1011, ids(0,0,0,0), '0, 3'b001, '0, '0, 1'b0);
        check_eq("gen0_2", 32'(gen[1:0]), 32'd2);
        cyc(4'b1011, ids(0,0,0,0), '0, 3'b001, '0, '0, 1'b0);
        check_eq("gen0_3", 32'(gen[1:0]), 32'd3);
        cyc(4'b1011, ids(0,0,0,0), '0, 3'b001, '0, '0, 1'b0);
        check_eq("gen0_wrap", 32'(gen[1:0]), 32'd0);
        cyc(4'b0001, ids(0,0,0,0), '0, '0, '0, '0, 1'b0);
        check_eq("arrived0_next_gen", 32'(dut.r_arrived[0]), 32'b0001);
        cyc(4'b1010, ids(0,0,0,0), '0, 3'b001, '0, '0, 1'b0);
        check_eq("gen0_after_wrap", 32'(gen[1:0]), 32'd1);

        // Unmasked and duplicate arrivals.
        cyc(4'b0100, ids(0,0,0,0), '0, '0, 3'b001, '0, 1'b0);
        cyc(4'b0001, ids(0,0,0,0), '0, '0, '0, '0, 1'b0);
        cyc(4'b0001, ids(0,0,0,0), '0, '0, 3'b001, '0, 1'b0);
        check_eq("arrived0_after_err", 32'(dut.r_arrived[0]), 32'b0001);
        cyc('0, '0, 3'b001, '0, '0, '0, 1'b0);
        check_eq("arrived0_abort", 32'(dut.r_arrived[0]), 32'd0);

        // Timeout 16 cycles after a lone arrival.
        cyc(4'b0001, ids(0,0,0,0), '0, '0, '0, '0, 1'b0);
        for (int i = 1; i <= 15; i++)
            cyc('0, '0, '0, '0, '0, (i == 15) ? 3'b001 : 3'b000, 1'b0);
        idle(1);
        check_eq("gen0_after_timeout", 32'(gen[1:0]), 32'd1);
        check_eq("arrived0_after_timeout", 32'(dut.r_arrived[0]), 32'd0);
        cyc(4'b1011, ids(0,0,0,0), '0, 3'b001, '0, '0, 1'b0);
        check_eq("gen0_after_to_release", 32'(gen[1:0]), 32'd2);

        // Mixed cycle: legal arrival, aborted arrival, out-of-range id; then idle-barrier arrival.
        cfg_write(2'd1, 4'b0011);
        check_eq("armed_b01", 32'(armed), 32'b011);
        cyc(4'b0111, ids(0,1,3,0), 3'b010, '0, '0, '0, 1'b1);
        check_eq("arrived0_mixed", 32'(dut.r_arrived[0]), 32'b0001);
        check_eq("arrived1_mixed", 32'(dut.r_arrived[1]), 32'd0);
        cyc(4'b1000, ids(0,0,0,2), '0, '0, 3'b100, '0, 1'b0);

        // Abort beats a completing set of arrivals.
        cyc(4'b1010, ids(0,0,0,0), 3'b001, '0, '0, '0, 1'b0);
        check_eq("arrived0_abort_win", 32'(dut.r_arrived[0]), 32'd0);
        check_eq("gen0_abort_win", 32'(gen[1:0]), 32'd2);

        // Reset in the middle of a generation.
        cyc(4'b0001, ids(0,0,0,0), '0, '0, '0, '0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_armed", 32'(armed), 32'd0);
        check_eq("midrst_gen", 32'(gen), 32'd0);
        check_eq("midrst_release", 32'(rel), 32'd0);
        check_eq("midrst_arrived0", 32'(dut.r_arrived[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("postrst_armed", 32'(armed), 32'd0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
